// File: rtl/date_pkg.sv
// rtl/date_pkg.sv - shared types and constants for the date controller
package date_pkg;

  localparam int YEAR_W = 15;
  localparam int MD_W   = 7;

  localparam logic [YEAR_W-1:0] YEAR_MIN  = 15'd2000;
  localparam logic [YEAR_W-1:0] YEAR_MAX  = 15'd2099;
  localparam logic [MD_W-1:0]   MONTH_MIN = 7'd1;
  localparam logic [MD_W-1:0]   MONTH_MAX = 7'd12;
  localparam logic [MD_W-1:0]   DAY_MIN   = 7'd1;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_SET_YEAR,
    ST_SET_MONTH,
    ST_SET_DAY,
    ST_COMMIT
  } state_e;

  typedef enum logic [1:0] {
    FIELD_NONE  = 2'd0,
    FIELD_YEAR  = 2'd1,
    FIELD_MONTH = 2'd2,
    FIELD_DAY   = 2'd3
  } field_e;

  // Divisible-by-4 is the whole leap rule inside 2000..2099.
  function automatic logic is_leap(input logic [YEAR_W-1:0] year);
    return (year[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/month_len.sv
// rtl/month_len.sv - days in a month for a given year
module month_len
  import date_pkg::*;
(
  input  logic [MD_W-1:0]   month_i,
  input  logic [YEAR_W-1:0] year_i,
  output logic [MD_W-1:0]   len_o
);

  // Table lookup; an out-of-range month reports 31 so nothing downstream clamps on garbage.
  always_comb begin
    len_o = 7'd31;
    case (month_i)
      7'd4, 7'd6, 7'd9, 7'd11: len_o = 7'd30;
      7'd2:                    len_o = is_leap(year_i) ? 7'd29 : 7'd28;
      default:                 len_o = 7'd31;
    endcase
  end

endmodule

// File: rtl/date_ctrl.sv
// rtl/date_ctrl.sv - day-advance strobe and user date-setting sequencer
module date_ctrl
  import date_pkg::*;
#(
  parameter int TIMEOUT    = 1000,
  parameter int BLINK_HALF = 250
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              midnight,
  input  logic              btn_mode,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic [YEAR_W-1:0] cur_year,
  input  logic [MD_W-1:0]   cur_month,
  input  logic [MD_W-1:0]   cur_day,
  output logic              day_tick,
  output logic              load,
  output logic [YEAR_W-1:0] load_year,
  output logic [MD_W-1:0]   load_month,
  output logic [MD_W-1:0]   load_day,
  output logic              editing,
  output logic [1:0]        edit_field,
  output logic              blink
);

  localparam int IDLE_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  state_e              state_q, state_d;
  logic [YEAR_W-1:0]   yr_q, yr_d, yr_n;
  logic [MD_W-1:0]     mo_q, mo_d, mo_n;
  logic [MD_W-1:0]     dy_q, dy_d;
  logic [MD_W-1:0]     len;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [BLINK_W-1:0]  bcnt_q, bcnt_d;
  logic                blink_q, blink_d;
  logic                tick_q, tick_d;

  logic in_edit, any_btn, step, start, timeout, year_ok;

  assign in_edit = (state_q == ST_SET_YEAR) || (state_q == ST_SET_MONTH) ||
                   (state_q == ST_SET_DAY);
  assign any_btn = btn_mode | btn_up | btn_down;
  assign step    = btn_up ^ btn_down;
  assign start   = (state_q == ST_RUN) && btn_mode && !midnight;
  assign timeout = in_edit && !any_btn && (idle_q == IDLE_LAST);
  assign year_ok = (cur_year >= YEAR_MIN) && (cur_year <= YEAR_MAX);

  // Length is taken on the post-edit year/month so a clamp lands in the same update.
  month_len u_month_len (
    .month_i (mo_n),
    .year_i  (yr_n),
    .len_o   (len)
  );

  // Next state: mode walks the fields, idle timeout abandons without committing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:       if (start) state_d = ST_SET_YEAR;
      ST_SET_YEAR:  if (timeout) state_d = ST_RUN; else if (btn_mode) state_d = ST_SET_MONTH;
      ST_SET_MONTH: if (timeout) state_d = ST_RUN; else if (btn_mode) state_d = ST_SET_DAY;
      ST_SET_DAY:   if (timeout) state_d = ST_RUN; else if (btn_mode) state_d = ST_COMMIT;
      ST_COMMIT:    state_d = ST_RUN;
      default:      state_d = ST_RUN;
    endcase
  end

  // Year/month up/down with wrap on the selected field.
  always_comb begin
    yr_n = yr_q;
    mo_n = mo_q;
    if (state_q == ST_SET_YEAR && step) begin
      if (btn_up) yr_n = (yr_q == YEAR_MAX) ? YEAR_MIN : yr_q + 15'd1;
      else        yr_n = (yr_q == YEAR_MIN) ? YEAR_MAX : yr_q - 15'd1;
    end
    if (state_q == ST_SET_MONTH && step) begin
      if (btn_up) mo_n = (mo_q == MONTH_MAX) ? MONTH_MIN : mo_q + 7'd1;
      else        mo_n = (mo_q == MONTH_MIN) ? MONTH_MAX : mo_q - 7'd1;
    end
  end

  // Shadow next values: capture on entry, day wrap, or day clamp after a year/month change.
  always_comb begin
    yr_d = yr_n;
    mo_d = mo_n;
    dy_d = dy_q;
    if (start) begin
      yr_d = year_ok ? cur_year : YEAR_MIN;
      mo_d = cur_month;
      dy_d = cur_day;
    end else if (state_q == ST_SET_DAY && step) begin
      if (btn_up) dy_d = (dy_q >= len) ? DAY_MIN : dy_q + 7'd1;
      else        dy_d = (dy_q <= DAY_MIN) ? len : dy_q - 7'd1;
    end else if ((state_q == ST_SET_YEAR || state_q == ST_SET_MONTH) && step &&
                 (dy_q > len)) begin
      dy_d = len;
    end
  end

  // Idle and blink timing; both sit at zero outside the edit states.
  always_comb begin
    idle_d  = '0;
    bcnt_d  = '0;
    blink_d = 1'b0;
    tick_d  = (state_q == ST_RUN) && midnight;
    if (in_edit) begin
      idle_d = any_btn ? '0 : idle_q + IDLE_W'(1);
      if (btn_up || btn_down) begin
        blink_d = 1'b1;
      end else if (bcnt_q == BLINK_LAST) begin
        blink_d = ~blink_q;
      end else begin
        bcnt_d  = bcnt_q + BLINK_W'(1);
        blink_d = blink_q;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

  // Shadow date, counters and the day strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      yr_q    <= YEAR_MIN;
      mo_q    <= MONTH_MIN;
      dy_q    <= DAY_MIN;
      idle_q  <= '0;
      bcnt_q  <= '0;
      blink_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      yr_q    <= yr_d;
      mo_q    <= mo_d;
      dy_q    <= dy_d;
      idle_q  <= idle_d;
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
      tick_q  <= tick_d;
    end
  end

  // Output decode from the current state.
  always_comb begin
    edit_field = FIELD_NONE;
    case (state_q)
      ST_SET_YEAR:  edit_field = FIELD_YEAR;
      ST_SET_MONTH: edit_field = FIELD_MONTH;
      ST_SET_DAY:   edit_field = FIELD_DAY;
      default:      edit_field = FIELD_NONE;
    endcase
  end

  assign day_tick   = tick_q;
  assign load       = (state_q == ST_COMMIT);
  assign load_year  = yr_q;
  assign load_month = mo_q;
  assign load_day   = dy_q;
  assign editing    = in_edit;
  assign blink      = blink_q & in_edit;

endmodule

// File: tb/tb_date_ctrl.sv
// tb/tb_date_ctrl.sv - vector table, corner sequences and random model check for date_ctrl
module tb_date_ctrl;

  localparam int TO = 40;
  localparam int BH = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        midnight, btn_mode, btn_up, btn_down;
  logic [14:0] cur_year;
  logic [6:0]  cur_month, cur_day;
  logic        day_tick, load, editing, blink;
  logic [14:0] load_year;
  logic [6:0]  load_month, load_day;
  logic [1:0]  edit_field;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  date_ctrl #(.TIMEOUT(TO), .BLINK_HALF(BH)) dut (
    .clk(clk), .rst(rst), .midnight(midnight), .btn_mode(btn_mode),
    .btn_up(btn_up), .btn_down(btn_down), .cur_year(cur_year),
    .cur_month(cur_month), .cur_day(cur_day), .day_tick(day_tick),
    .load(load), .load_year(load_year), .load_month(load_month),
    .load_day(load_day), .editing(editing), .edit_field(edit_field),
    .blink(blink)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic mid, input logic md, input logic up, input logic dn,
                       input int cy, input int cm, input int cd);
    midnight  = mid;
    btn_mode  = md;
    btn_up    = up;
    btn_down  = dn;
    cur_year  = 15'(cy);
    cur_month = 7'(cm);
    cur_day   = 7'(cd);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tick"},  day_tick,   0);
    check({tag, "_load"},  load,       0);
    check({tag, "_edit"},  editing,    0);
    check({tag, "_field"}, edit_field, 0);
    check({tag, "_blink"}, blink,      0);
    check({tag, "_year"},  load_year,  2000);
    check({tag, "_month"}, load_month, 1);
    check({tag, "_day"},   load_day,   1);
  endtask

  typedef struct {
    string name;
    logic  mid, md, up, dn;
    int    cy, cm, cd;
    logic  tick, ld;
    int    fld, y, m, d;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input string n, input logic mid, input logic md, input logic up,
                              input logic dn, input int cy, input int cm, input int cd,
                              input logic tick, input logic ld, input int fld,
                              input int y, input int m, input int d);
    vec_t v;
    v.name = n; v.mid = mid; v.md = md; v.up = up; v.dn = dn;
    v.cy = cy; v.cm = cm; v.cd = cd;
    v.tick = tick; v.ld = ld; v.fld = fld; v.y = y; v.m = m; v.d = d;
    vq.push_back(v);
  endfunction

  // Reference model: state as plain numbers, 0 run, 1..3 field, 4 commit.
  int   ms, my, mmo, mdy, mi, mb;
  logic mp, mt;

  function automatic int mlen(input int m, input int y);
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    if (m == 2) return (y % 4 == 0) ? 29 : 28;
    return 31;
  endfunction

  task automatic model_reset();
    ms = 0; my = 2000; mmo = 1; mdy = 1; mi = 0; mb = 0; mp = 1'b0; mt = 1'b0;
  endtask

  task automatic model_step(input logic mid, input logic md, input logic up, input logic dn,
                            input int cy, input int cm, input int cd);
    logic any, nt;
    int   l;
    nt  = (ms == 0) && mid;
    any = md | up | dn;
    if (ms == 0) begin
      if (md && !mid) begin
        ms = 1;
        my = (cy >= 2000 && cy <= 2099) ? cy : 2000;
        mmo = cm; mdy = cd;
      end
      mi = 0; mb = 0; mp = 1'b0;
    end else if (ms == 4) begin
      ms = 0; mi = 0; mb = 0; mp = 1'b0;
    end else if (!any && mi == TO - 1) begin
      ms = 0; mi = 0; mb = 0; mp = 1'b0;
    end else begin
      if (up != dn) begin
        if (ms == 1) begin
          if (up) my = (my == 2099) ? 2000 : my + 1;
          else    my = (my == 2000) ? 2099 : my - 1;
          if (mdy > mlen(mmo, my)) mdy = mlen(mmo, my);
        end else if (ms == 2) begin
          if (up) mmo = (mmo == 12) ? 1 : mmo + 1;
          else    mmo = (mmo == 1) ? 12 : mmo - 1;
          if (mdy > mlen(mmo, my)) mdy = mlen(mmo, my);
        end else begin
          l = mlen(mmo, my);
          if (up) mdy = (mdy >= l) ? 1 : mdy + 1;
          else    mdy = (mdy <= 1) ? l : mdy - 1;
        end
      end
      mi = any ? 0 : mi + 1;
      if (up || dn) begin
        mp = 1'b1; mb = 0;
      end else if (mb == BH - 1) begin
        mp = ~mp; mb = 0;
      end else begin
        mb = mb + 1;
      end
      if (md) ms = ms + 1;
    end
    mt = nt;
  endtask

  initial begin
    vec_t        v;
    int          drop, quiet;
    logic        saw_tick, saw_load, e, r_mid, r_md, r_up, r_dn;
    logic [34:0] exp_v, act_v;

    rst = 1'b0;
    drive(0, 0, 0, 0, 2023, 3, 31);
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    rst = 1'b1;
    cyc();
    check_reset_outputs("rst_rel");

    add("mid_tick",   1,0,0,0, 2023,3,31, 1,0,0, 0,0,0);
    add("mid_clear",  0,0,0,0, 2023,3,31, 0,0,0, 0,0,0);
    add("cl_m_y",     0,1,0,0, 2023,3,31, 0,0,1, 0,0,0);
    add("cl_m_m",     0,1,0,0, 2023,3,31, 0,0,2, 0,0,0);
    add("cl_m_dn",    0,0,0,1, 2023,3,31, 0,0,2, 0,0,0);
    add("cl_m_d",     0,1,0,0, 2023,3,31, 0,0,3, 0,0,0);
    add("cl_m_load",  0,1,0,0, 2023,3,31, 0,1,0, 2023,2,28);
    add("cl_m_end",   0,0,0,0, 2023,3,31, 0,0,0, 0,0,0);
    add("cl_y_y",     0,1,0,0, 2024,2,29, 0,0,1, 0,0,0);
    add("cl_y_up",    0,0,1,0, 2024,2,29, 0,0,1, 0,0,0);
    add("cl_y_m",     0,1,0,0, 2024,2,29, 0,0,2, 0,0,0);
    add("cl_y_d",     0,1,0,0, 2024,2,29, 0,0,3, 0,0,0);
    add("cl_y_load",  0,1,0,0, 2024,2,29, 0,1,0, 2025,2,28);
    add("cl_y_end",   0,0,0,0, 2024,2,29, 0,0,0, 0,0,0);
    add("wrap_y",     0,1,0,0, 2099,1,15, 0,0,1, 0,0,0);
    add("wrap_yup",   0,0,1,0, 2099,1,15, 0,0,1, 0,0,0);
    add("wrap_m",     0,1,0,0, 2099,1,15, 0,0,2, 0,0,0);
    add("wrap_mdn",   0,0,0,1, 2099,1,15, 0,0,2, 0,0,0);
    add("wrap_d",     0,1,0,0, 2099,1,15, 0,0,3, 0,0,0);
    add("wrap_dup",   0,0,1,0, 2099,1,15, 0,0,3, 0,0,0);
    add("wrap_ud",    0,0,1,1, 2099,1,15, 0,0,3, 0,0,0);
    add("wrap_load",  0,1,0,0, 2099,1,15, 0,1,0, 2000,12,16);
    add("wrap_end",   0,0,0,0, 2099,1,15, 0,0,0, 0,0,0);
    add("day_y",      0,1,0,0, 2030,4,30, 0,0,1, 0,0,0);
    add("day_m",      0,1,0,0, 2030,4,30, 0,0,2, 0,0,0);
    add("day_d",      0,1,0,0, 2030,4,30, 0,0,3, 0,0,0);
    add("day_up",     0,0,1,0, 2030,4,30, 0,0,3, 0,0,0);
    add("day_ud",     0,0,1,1, 2030,4,30, 0,0,3, 0,0,0);
    add("day_dn1",    0,0,0,1, 2030,4,30, 0,0,3, 0,0,0);
    add("day_dn2",    0,0,0,1, 2030,4,30, 0,0,3, 0,0,0);
    add("day_load",   0,1,0,0, 2030,4,30, 0,1,0, 2030,4,29);
    add("day_end",    0,0,0,0, 2030,4,30, 0,0,0, 0,0,0);
    add("both_tick",  1,1,0,0, 2030,4,30, 1,0,0, 0,0,0);
    add("both_after", 0,0,0,0, 2030,4,30, 0,0,0, 0,0,0);
    add("old_y",      0,1,0,0, 1999,5,5,  0,0,1, 0,0,0);
    add("old_m",      0,1,0,0, 1999,5,5,  0,0,2, 0,0,0);
    add("old_d",      0,1,0,0, 1999,5,5,  0,0,3, 0,0,0);
    add("old_load",   0,1,0,0, 1999,5,5,  0,1,0, 2000,5,5);
    add("old_end",    0,0,0,0, 1999,5,5,  0,0,0, 0,0,0);
    add("new_y",      0,1,0,0, 2100,6,6,  0,0,1, 0,0,0);
    add("new_m",      0,1,0,0, 2100,6,6,  0,0,2, 0,0,0);
    add("new_d",      0,1,0,0, 2100,6,6,  0,0,3, 0,0,0);
    add("new_load",   0,1,0,0, 2100,6,6,  0,1,0, 2000,6,6);
    add("new_end",    0,0,0,0, 2100,6,6,  0,0,0, 0,0,0);
    add("mup_y",      0,1,0,0, 2021,1,31, 0,0,1, 0,0,0);
    add("mup_m",      0,1,0,0, 2021,1,31, 0,0,2, 0,0,0);
    add("mup_up",     0,0,1,0, 2021,1,31, 0,0,2, 0,0,0);
    add("mup_d",      0,1,0,0, 2021,1,31, 0,0,3, 0,0,0);
    add("mup_load",   0,1,0,0, 2021,1,31, 0,1,0, 2021,2,28);
    add("mup_end",    0,0,0,0, 2021,1,31, 0,0,0, 0,0,0);
    add("m12_y",      0,1,0,0, 2021,12,31,0,0,1, 0,0,0);
    add("m12_m",      0,1,0,0, 2021,12,31,0,0,2, 0,0,0);
    add("m12_up",     0,0,1,0, 2021,12,31,0,0,2, 0,0,0);
    add("m12_d",      0,1,0,0, 2021,12,31,0,0,3, 0,0,0);
    add("m12_load",   0,1,0,0, 2021,12,31,0,1,0, 2021,1,31);
    add("m12_end",    0,0,0,0, 2021,12,31,0,0,0, 0,0,0);
    add("leap_y",     0,1,0,0, 2099,2,29, 0,0,1, 0,0,0);
    add("leap_up",    0,0,1,0, 2099,2,29, 0,0,1, 0,0,0);
    add("leap_m",     0,1,0,0, 2099,2,29, 0,0,2, 0,0,0);
    add("leap_d",     0,1,0,0, 2099,2,29, 0,0,3, 0,0,0);
    add("leap_load",  0,1,0,0, 2099,2,29, 0,1,0, 2000,2,29);
    add("leap_end",   0,0,0,0, 2099,2,29, 0,0,0, 0,0,0);
    add("ydn_y",      0,1,0,0, 2000,3,3,  0,0,1, 0,0,0);
    add("ydn_dn",     0,0,0,1, 2000,3,3,  0,0,1, 0,0,0);
    add("ydn_m",      0,1,0,0, 2000,3,3,  0,0,2, 0,0,0);
    add("ydn_d",      0,1,0,0, 2000,3,3,  0,0,3, 0,0,0);
    add("ydn_load",   0,1,0,0, 2000,3,3,  0,1,0, 2099,3,3);
    add("ydn_end",    0,0,0,0, 2000,3,3,  0,0,0, 0,0,0);

    foreach (vq[i]) begin
      v = vq[i];
      drive(v.mid, v.md, v.up, v.dn, v.cy, v.cm, v.cd);
      cyc();
      check({v.name, "_tick"},  day_tick,   v.tick);
      check({v.name, "_load"},  load,       v.ld);
      check({v.name, "_edit"},  editing,    (v.fld != 0));
      check({v.name, "_field"}, edit_field, v.fld);
      if (v.ld) begin
        check({v.name, "_year"},  load_year,  v.y);
        check({v.name, "_month"}, load_month, v.m);
        check({v.name, "_day"},   load_day,   v.d);
      end
    end
    drive(0, 0, 0, 0, 2023, 6, 10);
    cyc();

    // Idle timeout with a midnight during the edit.
    drive(0, 1, 0, 0, 2023, 6, 10);
    cyc();
    drive(0, 0, 1, 0, 2023, 6, 10);
    cyc();
    check("to_editing", editing, 1);
    drive(0, 0, 0, 0, 2023, 6, 10);
    drop = -1; saw_tick = 1'b0; saw_load = 1'b0;
    for (int k = 1; k <= TO + 5; k++) begin
      midnight = (k == 10);
      cyc();
      midnight = 1'b0;
      if (day_tick) saw_tick = 1'b1;
      if (load) saw_load = 1'b1;
      if (!editing && drop < 0) drop = k;
    end
    check("to_cycle", 64'(drop), 64'(TO));
    check("to_no_tick", saw_tick, 0);
    check("to_no_load", saw_load, 0);
    check("to_field", edit_field, 0);

    // Asynchronous reset in SET_MONTH.
    drive(0, 1, 0, 0, 2041, 7, 20);
    cyc();
    drive(0, 1, 0, 0, 2041, 7, 20);
    cyc();
    check("rm_field", edit_field, 2);
    drive(0, 0, 0, 0, 2041, 7, 20);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("rm_async");
    rst = 1'b1;
    cyc();
    check("rm_after_edit", editing, 0);
    check("rm_after_load", load, 0);

    // Random traffic against the reference model.
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    model_reset();
    quiet = 0;
    for (int c = 0; c < 4000; c++) begin
      if (quiet > 0) quiet--;
      else if ($urandom_range(0, 299) == 0) quiet = TO + 8;
      r_mid = ($urandom_range(0, 19) == 0);
      r_md  = (quiet == 0) && ($urandom_range(0, 9) == 0);
      r_up  = (quiet == 0) && ($urandom_range(0, 4) == 0);
      r_dn  = (quiet == 0) && ($urandom_range(0, 4) == 0);
      drive(r_mid, r_md, r_up, r_dn, int'($urandom_range(1990, 2110)),
            int'($urandom_range(1, 12)), int'($urandom_range(1, 31)));
      model_step(r_mid, r_md, r_up, r_dn, int'(cur_year), int'(cur_month), int'(cur_day));
      cyc();
      e = (ms >= 1 && ms <= 3);
      exp_v = {mt, logic'(ms == 4), e, 2'(e ? ms : 0), logic'(e && mp),
               15'(ms == 4 ? my : 0), 7'(ms == 4 ? mmo : 0), 7'(ms == 4 ? mdy : 0)};
      act_v = {day_tick, load, editing, edit_field, blink,
               load ? load_year : 15'd0, load ? load_month : 7'd0, load ? load_day : 7'd0};
      check($sformatf("rand_c%0d", c), act_v, exp_v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
